// File: rtl/sys_ctrl_regif.sv
// Command controller between the UART byte stream and the register file.
// Decodes AA/addr/data write frames and BB/addr read frames; read data goes back over TX.
module sys_ctrl_regif #(
  parameter int                 DATA_W     = 8,
  parameter int                 ADDR_W     = 4,
  parameter logic [DATA_W-1:0]  WR_CMD     = 8'hAA,
  parameter logic [DATA_W-1:0]  RD_CMD     = 8'hBB,
  parameter int                 RD_TIMEOUT = 8,
  parameter logic [DATA_W-1:0]  ERR_CODE   = 8'hEE
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  output logic              WrEn,
  output logic              RdEn,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WrData,
  input  logic [DATA_W-1:0] RdData,
  input  logic              RdData_valid,
  output logic [DATA_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD,
  input  logic              TX_BUSY,
  output logic              CMD_ERR,
  output logic              CTRL_BUSY
);

  // state   | meaning
  // IDLE    | waiting for an opcode byte
  // WR_ADDR | write opcode seen, waiting for address byte
  // WR_DATA | write address latched, waiting for data byte
  // RD_ADDR | read opcode seen, waiting for address byte
  // RD_WAIT | RdEn issued, waiting for RdData_valid or timeout
  // TX_SEND | reply byte held until the transmitter is free
  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       addr_bad;

  assign addr_bad = (RX_P_DATA[DATA_W-1:ADDR_W] != '0);

  // CTRL_BUSY is updated alongside every state change so it stays a flop output.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_D_VLD  <= 1'b0;
      CMD_ERR   <= 1'b0;
      CTRL_BUSY <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
    end else begin
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      TX_D_VLD <= 1'b0;
      CMD_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == WR_CMD) begin
              state     <= WR_ADDR;
              CTRL_BUSY <= 1'b1;
            end else if (RX_P_DATA == RD_CMD) begin
              state     <= RD_ADDR;
              CTRL_BUSY <= 1'b1;
            end else begin
              CMD_ERR <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            if (addr_bad) begin
              CMD_ERR   <= 1'b1;
              state     <= IDLE;
              CTRL_BUSY <= 1'b0;
            end else begin
              Address <= RX_P_DATA[ADDR_W-1:0];
              state   <= WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            WrData    <= RX_P_DATA;
            WrEn      <= 1'b1;
            state     <= IDLE;
            CTRL_BUSY <= 1'b0;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            if (addr_bad) begin
              CMD_ERR   <= 1'b1;
              state     <= IDLE;
              CTRL_BUSY <= 1'b0;
            end else begin
              Address <= RX_P_DATA[ADDR_W-1:0];
              RdEn    <= 1'b1;
              cnt     <= '0;
              state   <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (RX_D_VLD) CMD_ERR <= 1'b1;
          cnt <= cnt + 8'd1;
          // valid takes priority over a coincident timeout
          if (RdData_valid) begin
            TX_P_DATA <= RdData;
            state     <= TX_SEND;
          end else if (cnt == TO_LAST) begin
            TX_P_DATA <= ERR_CODE;
            CMD_ERR   <= 1'b1;
            state     <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (RX_D_VLD) CMD_ERR <= 1'b1;
          if (!TX_BUSY) begin
            TX_D_VLD  <= 1'b1;
            state     <= IDLE;
            CTRL_BUSY <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          CTRL_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl_regif.sv
// Bench for sys_ctrl_regif: register-file model plus scoreboard queues for
// writes, read addresses and transmitted bytes.
module tb_sys_ctrl_regif;

  localparam int RD_TIMEOUT = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic       WrEn, RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] RdData = '0;
  logic       RdData_valid = 1'b0;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       TX_BUSY = 1'b0;
  logic       CMD_ERR;
  logic       CTRL_BUSY;

  sys_ctrl_regif #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .RdData_valid(RdData_valid),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .CMD_ERR(CMD_ERR), .CTRL_BUSY(CTRL_BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0;
  int rd_cyc = 0, tx_cyc = 0, err_cyc = 0;
  bit model_en = 1'b1;
  logic [7:0] regs [16];

  logic [11:0] wr_q [$];
  logic [3:0]  rd_q [$];
  logic [7:0]  tx_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // register file with one cycle read latency
  always @(posedge CLK) begin
    RdData_valid <= 1'b0;
    if (RdEn && model_en) begin
      RdData_valid <= 1'b1;
      RdData       <= regs[Address];
    end
    if (WrEn) regs[Address] <= WrData;
  end

  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn || RdEn) check_val("wr_rd_exclusive", {31'd0, WrEn & RdEn}, 32'd0);
      if (WrEn) begin
        wr_cnt++;
        if (wr_q.size() == 0) check_val("wr_unexpected", 32'd1, 32'd0);
        else check_val("wr_addr_data", {20'd0, Address, WrData}, {20'd0, wr_q.pop_front()});
      end
      if (RdEn) begin
        rd_cnt++;
        rd_cyc = cyc;
        if (rd_q.size() == 0) check_val("rd_unexpected", 32'd1, 32'd0);
        else check_val("rd_addr", {28'd0, Address}, {28'd0, rd_q.pop_front()});
      end
      if (TX_D_VLD) begin
        tx_cnt++;
        tx_cyc = cyc;
        if (tx_q.size() == 0) check_val("tx_unexpected", 32'd1, 32'd0);
        else check_val("tx_byte", {24'd0, TX_P_DATA}, {24'd0, tx_q.pop_front()});
      end
      if (CMD_ERR) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int strobe_cyc);
    @(posedge CLK); #1;
    RX_P_DATA  = b;
    RX_D_VLD   = 1'b1;
    strobe_cyc = cyc;
    @(posedge CLK); #1;
    RX_D_VLD   = 1'b0;
  endtask

  task automatic wait_tx(input int prev, input int budget, input string tag);
    int n;
    n = 0;
    while (tx_cnt == prev && n < budget) begin
      @(posedge CLK);
      n++;
    end
    @(negedge CLK);
    if (tx_cnt == prev) check_val(tag, 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    int s, w0, r0, t0, e0, rel;
    for (int i = 0; i < 16; i++) regs[i] = '0;

    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_outputs", {WrEn, RdEn, TX_D_VLD, CMD_ERR, CTRL_BUSY}, 5'b0);
    check_val("rst_regs", {Address, WrData, TX_P_DATA}, 20'd0);
    @(posedge CLK); #1;
    RST = 1'b1;

    // write AA,05,3C
    w0 = wr_cnt; r0 = rd_cnt; t0 = tx_cnt; e0 = err_cnt;
    wr_q.push_back({4'h5, 8'h3C});
    send_byte(8'hAA, s);
    send_byte(8'h05, s);
    send_byte(8'h3C, s);
    idle_cycles(4);
    check_val("wr1_count", wr_cnt - w0, 1);
    check_val("wr1_no_rd_tx_err", (rd_cnt - r0) + (tx_cnt - t0) + (err_cnt - e0), 0);
    check_val("wr1_busy_after", {31'd0, CTRL_BUSY}, 0);

    // read BB,05 -> 3C, four cycles after the address strobe
    r0 = rd_cnt; t0 = tx_cnt;
    rd_q.push_back(4'h5);
    tx_q.push_back(8'h3C);
    send_byte(8'hBB, s);
    send_byte(8'h05, s);
    wait_tx(t0, 20, "rd1_tx_timeout");
    check_val("rd1_rden_lat", rd_cyc - s, 1);
    check_val("rd1_tx_lat", tx_cyc - s, 4);
    idle_cycles(3);
    check_val("rd1_counts", {rd_cnt - r0, tx_cnt - t0}, {32'd1, 32'd1});

    // read BB,02 with no RdData_valid -> timeout, EE
    model_en = 1'b0;
    e0 = err_cnt; t0 = tx_cnt;
    rd_q.push_back(4'h2);
    tx_q.push_back(8'hEE);
    send_byte(8'hBB, s);
    send_byte(8'h02, s);
    wait_tx(t0, 40, "to_tx_timeout");
    check_val("to_err_count", err_cnt - e0, 1);
    check_val("to_err_window",
              {31'd0, (err_cyc - s >= RD_TIMEOUT + 1) && (err_cyc - s <= RD_TIMEOUT + 2)}, 1);
    check_val("to_tx_after_err", tx_cyc - err_cyc, 1);
    idle_cycles(2);
    check_val("to_idle", {31'd0, CTRL_BUSY}, 0);
    model_en = 1'b1;

    // bad opcode then bad write address
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'h55, s);
    send_byte(8'hAA, s);
    send_byte(8'h17, s);
    idle_cycles(3);
    check_val("bad_err_count", err_cnt - e0, 2);
    check_val("bad_no_wr", wr_cnt - w0, 0);
    check_val("bad_busy_after", {31'd0, CTRL_BUSY}, 0);

    // read while the transmitter is busy, with a stray byte during the wait
    wr_q.push_back({4'h7, 8'h5A});
    send_byte(8'hAA, s);
    send_byte(8'h07, s);
    send_byte(8'h5A, s);
    TX_BUSY = 1'b1;
    t0 = tx_cnt; e0 = err_cnt;
    rd_q.push_back(4'h7);
    tx_q.push_back(8'h5A);
    send_byte(8'hBB, s);
    send_byte(8'h07, s);
    idle_cycles(6);
    send_byte(8'h11, s);
    while (cyc < s + 21) @(posedge CLK);
    @(negedge CLK);
    check_val("busy_no_tx", tx_cnt - t0, 0);
    check_val("busy_hold_data", {24'd0, TX_P_DATA}, 32'h5A);
    check_val("busy_ctrl_busy", {31'd0, CTRL_BUSY}, 1);
    check_val("busy_stray_err", err_cnt - e0, 1);
    @(posedge CLK); #1;
    TX_BUSY = 1'b0;
    rel = cyc;
    wait_tx(t0, 10, "busy_tx_timeout");
    check_val("busy_tx_lat", tx_cyc - rel, 1);

    // reset mid-frame
    idle_cycles(2);
    w0 = wr_cnt; e0 = err_cnt;
    send_byte(8'hAA, s);
    send_byte(8'h03, s);
    @(negedge CLK);
    check_val("mid_addr_latched", {28'd0, Address}, 3);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check_val("mid_rst_outputs", {WrEn, RdEn, TX_D_VLD, CMD_ERR, CTRL_BUSY}, 5'b0);
    check_val("mid_rst_regs", {Address, WrData, TX_P_DATA}, 20'd0);
    send_byte(8'h3C, s);
    idle_cycles(3);
    check_val("mid_err_3c", err_cnt - e0, 1);
    check_val("mid_no_wr", wr_cnt - w0, 0);

    check_val("queues_empty", wr_q.size() + rd_q.size() + tx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
